fifo: RTL and testbench



---
 rtl/fifo.sv | 80 ++++++++
 tb/tb_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Purpose  : Single-clock valid/ready FIFO with full-throughput push/pop,
//            push-while-full and zero-latency bypass when empty.
// Revision : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [C_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [C_CW-1:0]  count_q,  count_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_wr_en;
  logic w_rd_en;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == C_CW'(DEPTH));
  assign in_ready  = !rst && (!w_full || out_ready);
  assign out_valid = !rst && (!w_empty || in_valid);
  assign out_data  = w_empty ? in_data : mem_q[rd_ptr_q];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // A simultaneous push/pop while empty is a pure bypass: nothing is stored.
  assign w_wr_en = w_push && !(w_empty && w_pop);
  assign w_rd_en = w_pop && !w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_en) wr_ptr_d = wr_ptr_q + C_AW'(1);
    if (w_rd_en) rd_ptr_d = rd_ptr_q + C_AW'(1);
    case ({w_wr_en, w_rd_en})
      2'b10:   count_d = count_q + C_CW'(1);
      2'b01:   count_d = count_q - C_CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo
// Purpose  : Directed self-checking bench for fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fill_vec [8];
  logic [7:0] pop_vec  [8];

  fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1ns after it and outputs sampled 2ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fill_vec = '{8'hFE, 8'hED, 8'hDC, 8'hCB, 8'hBA, 8'hA9, 8'h98, 8'h87};
    pop_vec  = '{8'hED, 8'hDC, 8'hCB, 8'hBA, 8'hA9, 8'h98, 8'h87, 8'h01};

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    tick(); tick();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); #1;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);

    // Fill to capacity.
    for (int i = 0; i < 8; i++) begin
      in_data = fill_vec[i]; in_valid = 1'b1;
      #1;
      check("fill_in_ready", in_ready, 1);
      tick();
      if (i == 0) begin
        in_valid = 1'b0; #1;
        check("first_out_valid", out_valid, 1);
        check("first_out_data", out_data, 8'hFE);
      end
    end
    in_valid = 1'b0; #1;
    check("full_in_ready", in_ready, 0);
    check("full_count", dut.count_q, 8);
    check("full_head", out_data, 8'hFE);

    // Push while full.
    in_data = 8'h01; in_valid = 1'b1; #1;
    check("full_hold_in_ready", in_ready, 0);
    out_ready = 1'b1; #1;
    check("pwf_in_ready", in_ready, 1);
    check("pwf_out_data", out_data, 8'hFE);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    check("pwf_count", dut.count_q, 8);

    // Drain.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, pop_vec[i]);
      tick();
    end
    #1;
    check("drained_valid", out_valid, 0);
    check("drained_count", dut.count_q, 0);

    // Push, then push with simultaneous pop.
    out_ready = 1'b0; in_data = 8'h76; in_valid = 1'b1;
    tick();
    in_data = 8'h65; out_ready = 1'b1; #1;
    check("pp_out_data", out_data, 8'h76);
    check("pp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; #1;
    check("pp_count", dut.count_q, 1);
    check("pp_second_valid", out_valid, 1);
    check("pp_second_data", out_data, 8'h65);
    tick(); #1;
    check("pp_empty_valid", out_valid, 0);

    // Bypass while empty.
    in_data = 8'h54; in_valid = 1'b1; out_ready = 1'b1; #1;
    check("byp_out_valid", out_valid, 1);
    check("byp_out_data", out_data, 8'h54);
    check("byp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; #1;
    check("byp_count", dut.count_q, 0);
    check("byp_after_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
